// File: rtl/inst_queue_pkg.sv
// Shared CPU definitions: word widths, MIPS field bit positions and the NOP encoding.
package inst_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // Most-significant bit of each MIPS instruction field.
    localparam int OPCODE_MSB = 31;
    localparam int RS_MSB     = 25;
    localparam int RT_MSB     = 20;
    localparam int RD_MSB     = 15;
    localparam int SHAMT_MSB  = 10;
    localparam int FUNCT_MSB  = 5;
    localparam int IMM_MSB    = 15;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    // One queue slot: the instruction word together with the PC it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/inst_queue_fields.sv
// Combinational splitter of a 32-bit MIPS word into its fixed-position fields.
// Shared by the instruction queue, decode stage and control unit.
module inst_fields
    import inst_queue_pkg::*;
(
    input  logic [INST_W-1:0]   inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [IMM_W-1:0]    imm16
);

    assign opcode = inst[OPCODE_MSB -: OPCODE_W];
    assign rs     = inst[RS_MSB     -: REG_W];
    assign rt     = inst[RT_MSB     -: REG_W];
    assign rd     = inst[RD_MSB     -: REG_W];
    assign shamt  = inst[SHAMT_MSB  -: SHAMT_W];
    assign funct  = inst[FUNCT_MSB  -: FUNCT_W];
    assign imm16  = inst[IMM_MSB    -: IMM_W];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. First-word fall-through: the head
// entry and its pre-split fields are presented combinationally; NOP/0 when empty.
// A taken branch/jump flushes all entries synchronously.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm16,
    output logic [CNT_W-1:0]  count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    entry_t           head;

    // Full blocks pushes even when a pop happens in the same cycle, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; the array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end

    // Head mux masks unwritten storage while empty so no X reaches decode.
    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign out_inst = out_valid ? head.inst : NOP_INST;
    assign out_pc   = out_valid ? head.pc   : '0;

    inst_fields u_fields (
        .inst   (out_inst),
        .opcode (out_opcode),
        .rs     (out_rs),
        .rt     (out_rt),
        .rd     (out_rd),
        .shamt  (out_shamt),
        .funct  (out_funct),
        .imm16  (out_imm16)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm16;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    inst_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_funct  (out_funct),
        .out_imm16  (out_imm16),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_inst [4];
    logic [31:0] fill_pc   [4];

    initial begin
        fill_inst[0] = 32'h8C82_0004; fill_pc[0] = 32'h00;
        fill_inst[1] = 32'h00A6_2020; fill_pc[1] = 32'h04;
        fill_inst[2] = 32'h1000_FFFF; fill_pc[2] = 32'h08;
        fill_inst[3] = 32'hAC82_0008; fill_pc[3] = 32'h0C;

        // Reset held with fetch presenting a word.
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_inst = fill_inst[0]; in_pc = fill_pc[0];
        step();
        step();
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_inst",  out_inst,       32'h0);
        chk("rst_out_pc",    out_pc,         32'h0);
        chk("rst_opcode",    32'(out_opcode),32'd0);

        // Release reset; first push visible after one edge.
        rst_n = 1'b1;
        step();
        chk("first_count",   32'(count),     32'd1);
        chk("first_valid",   32'(out_valid), 32'd1);
        chk("first_inst",    out_inst,       32'h8C82_0004);
        chk("first_pc",      out_pc,         32'h0);

        // Fill the remaining three slots with out_ready low.
        for (int i = 1; i < 4; i++) begin
            in_inst = fill_inst[i]; in_pc = fill_pc[i];
            step();
        end
        chk("full_count",    32'(count),     32'd4);
        chk("full_in_ready", 32'(in_ready),  32'd0);

        // Fifth push is ignored.
        in_inst = 32'hDEAD_BEEF; in_pc = 32'h10;
        step();
        chk("fifth_count",   32'(count),     32'd4);
        chk("head_inst",     out_inst,       32'h8C82_0004);
        chk("head_opcode",   32'(out_opcode),32'h23);
        chk("head_rs",       32'(out_rs),    32'd4);
        chk("head_rt",       32'(out_rt),    32'd2);
        chk("head_imm16",    32'(out_imm16), 32'h0004);

        // Drain in order.
        in_valid = 1'b0; out_ready = 1'b1;
        chk("d0_inst", out_inst, 32'h8C82_0004);
        chk("d0_pc",   out_pc,   32'h00);
        step();
        chk("d1_count",  32'(count),     32'd3);
        chk("d1_inst",   out_inst,       32'h00A6_2020);
        chk("d1_pc",     out_pc,         32'h04);
        chk("d1_opcode", 32'(out_opcode),32'h00);
        chk("d1_rs",     32'(out_rs),    32'd5);
        chk("d1_rt",     32'(out_rt),    32'd6);
        chk("d1_rd",     32'(out_rd),    32'd4);
        chk("d1_shamt",  32'(out_shamt), 32'd0);
        chk("d1_funct",  32'(out_funct), 32'h20);
        step();
        chk("d2_count",  32'(count),     32'd2);
        chk("d2_inst",   out_inst,       32'h1000_FFFF);
        chk("d2_pc",     out_pc,         32'h08);
        chk("d2_opcode", 32'(out_opcode),32'h04);
        chk("d2_imm16",  32'(out_imm16), 32'hFFFF);
        step();
        chk("d3_count",  32'(count),     32'd1);
        chk("d3_inst",   out_inst,       32'hAC82_0008);
        chk("d3_pc",     out_pc,         32'h0C);
        chk("d3_opcode", 32'(out_opcode),32'h2B);
        chk("d3_rs",     32'(out_rs),    32'd4);
        chk("d3_rt",     32'(out_rt),    32'd2);
        chk("d3_imm16",  32'(out_imm16), 32'h0008);
        step();
        chk("empty_count", 32'(count),     32'd0);
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_inst",  out_inst,       32'h0);
        chk("empty_pc",    out_pc,         32'h0);
        chk("empty_rd",    32'(out_rd),    32'd0);
        chk("empty_ready", 32'(in_ready),  32'd1);

        // out_ready while empty is ignored.
        step();
        chk("empty_pop_count", 32'(count), 32'd0);

        // Streaming 20 words with push and pop every cycle; pointers wrap 5 times.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_inst = 32'h1000_0000 + 32'(i);
            in_pc   = 32'h100 + 32'(4 * i);
            step();
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_inst",  out_inst,   32'h1000_0000 + 32'(i));
            chk("stream_pc",    out_pc,     32'h100 + 32'(4 * i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_count", 32'(count), 32'd0);

        // Fill to full, then push+pop together: pop happens, push refused.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_inst = 32'hA000_0000 + 32'(i);
            in_pc   = 32'h200 + 32'(4 * i);
            step();
        end
        chk("full2_count", 32'(count), 32'd4);
        in_inst = 32'hBBBB_BBBB; in_pc = 32'h300;
        out_ready = 1'b1;
        step();
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_inst",  out_inst,   32'hA000_0001);
        chk("fullpop_pc",    out_pc,     32'h204);

        // Flush with push and pop requested in the same cycle.
        flush = 1'b1; in_inst = 32'hCCCC_CCCC; in_pc = 32'h400;
        step();
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_inst",  out_inst,       32'h0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("postflush_count", 32'(count),     32'd0);
        chk("postflush_valid", 32'(out_valid), 32'd0);

        // After flush the pointers restart: a new word becomes head.
        in_valid = 1'b1; in_inst = 32'h2402_0007; in_pc = 32'h500;
        step();
        in_inst = 32'h2403_0008; in_pc = 32'h504;
        step();
        in_valid = 1'b0;
        chk("pre_arst_count", 32'(count), 32'd2);
        chk("pre_arst_inst",  out_inst,   32'h2402_0007);

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_inst",  out_inst,       32'h0);
        chk("arst_pc",    out_pc,         32'h0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_inst = 32'h3C01_1234; in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        chk("post_arst_count", 32'(count), 32'd1);
        chk("post_arst_inst",  out_inst,   32'h3C01_1234);
        chk("post_arst_pc",    out_pc,     32'h600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction queue between the instruction-fetch stage and decode/register-read.
- Buffers fetched instruction words with their PC so a decode stall does not lose fetched words.
- First-word fall-through: head entry and its pre-split MIPS fields are presented combinationally to decode.
- Flushed on a taken branch or jump, discarding wrong-path instructions.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
PTR_W, 2, pointer width, log2(DEPTH)
CNT_W, 3, occupancy counter width, log2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries (taken branch/jump)
in_valid  input  1  fetch presents a word this cycle
in_inst  input  32  fetched instruction word
in_pc  input  32  PC of in_inst
in_ready  output  1  queue can accept a word: (count != DEPTH)
out_valid  output  1  head entry valid: (count != 0)
out_ready  input  1  decode consumes head this cycle
out_inst  output  32  head instruction; 32'h00000000 (NOP) when empty
out_pc  output  32  head PC; 0 when empty
out_opcode  output  6  out_inst[31:26]
out_rs  output  5  out_inst[25:21]
out_rt  output  5  out_inst[20:16]
out_rd  output  5  out_inst[15:11]
out_shamt  output  5  out_inst[10:6]
out_funct  output  6  out_inst[5:0]
out_imm16  output  16  out_inst[15:0]
count  output  CNT_W  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr and count go to 0 immediately. Storage array is not reset. Outputs are then out_valid=0, in_ready=1, out_inst=0, out_pc=0 and all fields 0.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push: on the clock edge, the entry at wr_ptr takes {in_pc, in_inst} and wr_ptr increments.
- Pop: on the clock edge, rd_ptr increments.
- Count: +1 on push only, -1 on pop only, unchanged on both.
- Pointers wrap modulo DEPTH through natural PTR_W overflow.
- Latency: a word pushed at edge N is visible on out_* after edge N (same cycle it becomes head). Minimum fetch-to-decode latency is one cycle.
- Full (count==DEPTH): in_ready=0 and no push, even if a pop occurs the same cycle. This deliberately avoids a combinational in_ready/out_ready path; fetch must hold its PC while in_ready=0.
- Empty (count==0): out_valid=0; out_ready is ignored.
- Simultaneous push and pop with 0<count<DEPTH: both happen, count unchanged.
- Push and pop on the same entry index is legal only when count==DEPTH, which cannot occur since push is blocked when full.
- Flush: synchronous. At the edge, pointers and count go to 0. Any push or pop in the flush cycle is discarded. The queue is empty in the following cycle.
- Flush has priority over push and pop. Reset has priority over flush.
- Reset asserted mid-operation: all contents are lost; behaviour is identical to power-on reset.
- Field outputs are pure slices of out_inst, so they are all 0 when empty.
- Head output mux: out_inst = out_valid ? mem[rd_ptr].inst : 0 (same for out_pc).
- No X may propagate to outputs after reset, because uninitialised storage is masked whenever the queue is empty.

Decomposition:
- Shared package/header cpu_defs.vh holds:
  - field bit-position constants (OPCODE_MSB=31, RS_MSB=25, RT_MSB=20, RD_MSB=15, SHAMT_MSB=10, FUNCT_MSB=5);
  - NOP_INST=32'h00000000;
  - INST_W=32 and PC_W=32.
- One sub-module is natural: inst_fields, a combinational splitter from a 32-bit word to opcode/rs/rt/rd/shamt/funct/imm16. It is reused by the decode stage and control unit.
- Storage and pointers stay in inst_queue.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_inst=0. Release rst_n -> first push visible after one edge.
- Fill/drain: push 0x8C820004@pc0x00, 0x00A62020@pc0x04, 0x1000FFFF@pc0x08, 0xAC820008@pc0x0C with out_ready=0 -> count=4 and in_ready=0. A fifth push is ignored. Then pop 4 times -> words emerge in order with correct PC and fields. The first head shows opcode=0x23, rs=4, rt=2, imm16=0x0004.
- Streaming: in_valid=1 and out_ready=1 every cycle for 20 words -> count stays at 1 after the first edge, output order matches input, and the pointers wrap past DEPTH several times.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop occurs and push is refused; count=3 next cycle.
- Flush: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0, and the pushed word never appears.
- Async reset mid-stream: drop rst_n between clock edges with count=2 -> outputs clear immediately without waiting for a clock edge.
